// File: rtl/sgpr_operand_collector.sv
// sgpr_operand_collector: issues 1-2 SGPR reads per instruction, merges the fixed-latency responses into 64-bit operands and queues them; ports: issue_* request in, rd_req_*/rd_resp_* RAM side, opnd_* valid/ready bundle out
module sgpr_operand_collector #(
  parameter int NUM_OPS    = 3,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 2,
  parameter int TAG_W      = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [NUM_OPS*ADDR_W-1:0] issue_addr,
  input  logic [NUM_OPS-1:0]        issue_is64,
  input  logic [TAG_W-1:0]          issue_tag,
  output logic                      rd_req_valid,
  output logic [NUM_OPS*ADDR_W-1:0] rd_req_addr,
  input  logic                      rd_resp_valid,
  input  logic [NUM_OPS*32-1:0]     rd_resp_data,
  output logic                      opnd_valid,
  input  logic                      opnd_ready,
  output logic [NUM_OPS*64-1:0]     opnd_data,
  output logic [TAG_W-1:0]          opnd_tag
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int PTW = PW + 1;
  localparam int SW  = $clog2(RD_LATENCY + 1);
  typedef enum logic {IDLE, HI} state_t;
  state_t state;
  logic [CW-1:0] credits, credits_nx;
  logic [NUM_OPS*ADDR_W-1:0] lat_addr, hi_addr;
  logic [NUM_OPS-1:0] lat_is64;
  logic [TAG_W-1:0] lat_tag;
  logic accept, pop, push, any64, in_hi;
  logic [RD_LATENCY-1:0] sh_v, sh_hi, sh_last;
  logic [NUM_OPS-1:0] sh_is64 [RD_LATENCY];
  logic [TAG_W-1:0] sh_tag [RD_LATENCY];
  logic o_v, o_hi, o_last;
  logic [NUM_OPS-1:0] o_is64;
  logic [TAG_W-1:0] o_tag;
  logic [NUM_OPS*64-1:0] asm_q, merged;
  logic [NUM_OPS*64-1:0] f_data [FIFO_DEPTH];
  logic [TAG_W-1:0] f_tag [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic empty, full;
  logic [SW-1:0] settle;
  assign in_hi        = state == HI;
  assign accept       = issue_valid && issue_ready;
  assign pop          = opnd_valid && opnd_ready;
  assign any64        = |issue_is64;
  assign credits_nx   = credits + CW'(accept) - CW'(pop);
  assign rd_req_valid = accept || in_hi;
  assign rd_req_addr  = in_hi ? hi_addr : accept ? issue_addr : '0;
  assign o_v    = sh_v[RD_LATENCY-1];
  assign o_hi   = sh_hi[RD_LATENCY-1];
  assign o_last = sh_last[RD_LATENCY-1];
  assign o_is64 = sh_is64[RD_LATENCY-1];
  assign o_tag  = sh_tag[RD_LATENCY-1];
  assign push   = o_v && o_last;
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_slot
    assign hi_addr[g*ADDR_W +: ADDR_W] = lat_addr[g*ADDR_W +: ADDR_W] + ADDR_W'(lat_is64[g]);
    assign merged[g*64 +: 64] = !o_hi ? {32'd0, rd_resp_data[g*32 +: 32]} :
                                o_is64[g] ? {rd_resp_data[g*32 +: 32], asm_q[g*64 +: 32]} :
                                asm_q[g*64 +: 64];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      credits     <= '0;
      issue_ready <= 1'b0;
      lat_addr    <= '0;
      lat_is64    <= '0;
      lat_tag     <= '0;
    end else begin
      state       <= accept && any64 ? HI : IDLE;
      credits     <= credits_nx;
      issue_ready <= !(accept && any64) && credits_nx < CW'(FIFO_DEPTH);
      if (accept) begin
        lat_addr <= issue_addr;
        lat_is64 <= issue_is64;
        lat_tag  <= issue_tag;
      end
    end
  // Responses carry no identity: the shadow entry at the last stage describes the data on rd_resp_data.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_v    <= '0;
      sh_hi   <= '0;
      sh_last <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        sh_is64[i] <= '0;
        sh_tag[i]  <= '0;
      end
    end else begin
      sh_v[0]    <= rd_req_valid;
      sh_hi[0]   <= in_hi;
      sh_last[0] <= in_hi || !any64;
      sh_is64[0] <= in_hi ? lat_is64 : issue_is64;
      sh_tag[0]  <= in_hi ? lat_tag : issue_tag;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sh_v[i]    <= sh_v[i-1];
        sh_hi[i]   <= sh_hi[i-1];
        sh_last[i] <= sh_last[i-1];
        sh_is64[i] <= sh_is64[i-1];
        sh_tag[i]  <= sh_tag[i-1];
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) asm_q <= '0;
    else if (o_v) asm_q <= merged;
  assign empty      = wr_ptr == rd_ptr;
  assign full       = wr_ptr[PW] != rd_ptr[PW] && wr_ptr[PW-1:0] == rd_ptr[PW-1:0];
  assign opnd_valid = !empty;
  assign opnd_data  = empty ? '0 : f_data[rd_ptr[PW-1:0]];
  assign opnd_tag   = empty ? '0 : f_tag[rd_ptr[PW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTW'(push);
      rd_ptr <= rd_ptr + PTW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      f_data[wr_ptr[PW-1:0]] <= merged;
      f_tag[wr_ptr[PW-1:0]]  <= o_tag;
    end
  // Stale responses for requests flushed by reset may still arrive for RD_LATENCY cycles.
  always_ff @(posedge clk or posedge rst)
    if (rst) settle <= '0;
    else if (settle != SW'(RD_LATENCY)) settle <= settle + SW'(1);
  a_resp: assert property (@(posedge clk) disable iff (rst) settle == SW'(RD_LATENCY) |-> rd_resp_valid == o_v);
  a_push: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_cred: assert property (@(posedge clk) disable iff (rst) !(pop && credits == '0));
endmodule

// File: tb/tb_sgpr_operand_collector.sv
// tb_sgpr_operand_collector: randomized and directed checks of sgpr_operand_collector against a queue-based reference model
module tb_sgpr_operand_collector;
  localparam int N = 3, AW = 8, L = 2, TW = 6, D = 4;
  logic clk = 0, rst = 1;
  logic issue_valid, issue_ready, rd_req_valid, rd_resp_valid, opnd_valid, opnd_ready;
  logic [N*AW-1:0] issue_addr, rd_req_addr;
  logic [N-1:0] issue_is64;
  logic [TW-1:0] issue_tag, opnd_tag;
  logic [N*32-1:0] rd_resp_data;
  logic [N*64-1:0] opnd_data;
  int checks = 0, fails = 0;
  bit ram_ident = 1;
  always #5 clk = ~clk;
  sgpr_operand_collector #(.NUM_OPS(N), .ADDR_W(AW), .RD_LATENCY(L), .TAG_W(TW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_addr(issue_addr), .issue_is64(issue_is64), .issue_tag(issue_tag),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_data(opnd_data), .opnd_tag(opnd_tag)
  );
  function automatic logic [31:0] memf(input logic [7:0] a, input bit ident);
    return ident ? {24'd0, a} : {a ^ 8'hA5, ~a, 8'(a + 8'd77), a};
  endfunction
  logic pv [L];
  logic [N*AW-1:0] pa [L];
  always @(posedge clk) begin
    pv[0] <= rd_req_valid;
    pa[0] <= rd_req_addr;
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  always_comb begin
    rd_resp_valid = pv[L-1];
    rd_resp_data = '0;
    for (int i = 0; i < N; i++) rd_resp_data[i*32 +: 32] = memf(pa[L-1][i*AW +: AW], ram_ident);
  end
  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {logic [191:0] d; logic [TW-1:0] t; int rt;} ent_t;
  ent_t q[$];
  int outstanding = 0, since_rst = 0, cyc = 0;
  bit hi_pend = 0;
  logic [N*AW-1:0] hi_exp;
  always @(negedge clk) begin
    bit acc, ev;
    ent_t e;
    cyc++;
    if (rst) begin
      q.delete();
      outstanding = 0;
      since_rst = 0;
      hi_pend = 0;
    end else begin
      acc = issue_valid && issue_ready;
      ev = q.size() > 0 && q[0].rt <= cyc;
      chk("issue_ready", issue_ready, since_rst > 0 && !hi_pend && outstanding < D);
      chk("rd_req_valid", rd_req_valid, acc || hi_pend);
      if (acc) chk("rd_req_addr_lo", rd_req_addr, issue_addr);
      if (hi_pend) chk("rd_req_addr_hi", rd_req_addr, hi_exp);
      chk("opnd_valid", opnd_valid, ev);
      if (ev) begin
        chk("opnd_data", opnd_data, q[0].d);
        chk("opnd_tag", opnd_tag, q[0].t);
        if (opnd_ready) begin
          void'(q.pop_front());
          outstanding--;
        end
      end
      hi_pend = 0;
      if (acc) begin
        for (int i = 0; i < N; i++) begin
          logic [7:0] a, b;
          a = issue_addr[i*AW +: AW];
          b = 8'(a + 8'd1);
          e.d[i*64 +: 64] = {issue_is64[i] ? memf(b, ram_ident) : 32'd0, memf(a, ram_ident)};
          hi_exp[i*AW +: AW] = issue_is64[i] ? b : a;
        end
        e.t = issue_tag;
        e.rt = cyc + L + 1 + int'(|issue_is64);
        q.push_back(e);
        outstanding++;
        hi_pend = |issue_is64;
      end
      since_rst++;
    end
  end
  task automatic do_issue(input logic [N*AW-1:0] a, input logic [N-1:0] w, input logic [TW-1:0] t);
    bit ok = 0;
    issue_addr = a;
    issue_is64 = w;
    issue_tag = t;
    issue_valid = 1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = issue_ready;
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL issue_timeout: got ready 0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1 issue_valid = 0;
  endtask
  task automatic reset_chk();
    chk("rst_issue_ready", issue_ready, 0);
    chk("rst_rd_req_valid", rd_req_valid, 0);
    chk("rst_rd_req_addr", rd_req_addr, 0);
    chk("rst_opnd_valid", opnd_valid, 0);
    chk("rst_opnd_data", opnd_data, 0);
    chk("rst_opnd_tag", opnd_tag, 0);
  endtask
  task automatic set_bp(input int i);
    issue_addr = {8'(3*i+2), 8'(3*i+1), 8'(3*i)};
    issue_is64 = 0;
    issue_tag = 6'(40 + i);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int acc, sent;
    bit accd;
    issue_valid = 0; issue_addr = 0; issue_is64 = 0; issue_tag = 0; opnd_ready = 0;
    repeat (3) @(negedge clk);
    reset_chk();
    @(posedge clk); #2 rst = 0;
    @(posedge clk); #1 opnd_ready = 1;
    do_issue({8'd7, 8'd6, 8'd5}, 3'b000, 6'd3);
    repeat (2) @(negedge clk);
    chk("t1_early", opnd_valid, 0);
    @(negedge clk);
    chk("t1_valid", opnd_valid, 1);
    chk("t1_data", opnd_data, {64'd7, 64'd6, 64'd5});
    chk("t1_tag", opnd_tag, 3);
    @(posedge clk); #1;
    do_issue({8'd30, 8'd20, 8'd10}, 3'b010, 6'd5);
    @(negedge clk);
    chk("t2_hi_valid", rd_req_valid, 1);
    chk("t2_hi_addr", rd_req_addr, {8'd30, 8'd21, 8'd10});
    repeat (2) @(negedge clk);
    chk("t2_early", opnd_valid, 0);
    @(negedge clk);
    chk("t2_valid", opnd_valid, 1);
    chk("t2_data", opnd_data, {64'd30, 64'h00000015_00000014, 64'd10});
    chk("t2_tag", opnd_tag, 5);
    @(posedge clk); #1;
    do_issue({8'd2, 8'd1, 8'd255}, 3'b001, 6'd9);
    @(negedge clk);
    chk("t3_wrap_addr", rd_req_addr, {8'd2, 8'd1, 8'd0});
    repeat (3) @(negedge clk);
    chk("t3_data", opnd_data, {64'd2, 64'd1, 64'h00000000_000000ff});
    @(posedge clk); #1 opnd_ready = 0;
    acc = 0;
    set_bp(0);
    issue_valid = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (issue_ready) acc++;
      @(posedge clk); #1;
      if (acc < 6) set_bp(acc);
    end
    @(negedge clk);
    chk("t4_accepted", acc, 4);
    chk("t4_ready_low", issue_ready, 0);
    @(posedge clk); #1 opnd_ready = 1;
    for (int k = 0; k < 40 && acc < 6; k++) begin
      @(negedge clk);
      if (issue_ready) acc++;
      @(posedge clk); #1;
      if (acc < 6) set_bp(acc); else issue_valid = 0;
    end
    issue_valid = 0;
    chk("t4_all_accepted", acc, 6);
    for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
    chk("t4_drained", q.size(), 0);
    @(posedge clk); #1 ram_ident = 0;
    sent = 0;
    for (int k = 0; k < 3000 && sent < 40; k++) begin
      @(negedge clk);
      accd = issue_valid && issue_ready;
      if (accd) sent++;
      @(posedge clk); #1;
      if (!issue_valid || accd) begin
        issue_valid = sent < 40 && $urandom_range(3) != 0;
        for (int i = 0; i < N; i++) issue_addr[i*AW +: AW] = $urandom_range(3) == 0 ? 8'hFF : 8'($urandom);
        issue_is64 = $urandom_range(1) ? 3'($urandom) : 3'b000;
        issue_tag = 6'($urandom);
      end
      opnd_ready = (k % 30) < 10 ? 1'b0 : $urandom_range(4) != 0;
    end
    issue_valid = 0;
    opnd_ready = 1;
    chk("t5_sent", sent, 40);
    for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clk);
    chk("t5_drained", q.size(), 0);
    @(posedge clk); #1 ram_ident = 1;
    do_issue({8'd12, 8'd11, 8'd10}, 3'b000, 6'd20);
    do_issue({8'd15, 8'd14, 8'd13}, 3'b100, 6'd21);
    #1 rst = 1;
    #1 reset_chk();
    @(posedge clk); #2 rst = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t6_no_stale", opnd_valid, 0);
    end
    @(posedge clk); #1;
    do_issue({8'd42, 8'd41, 8'd40}, 3'b000, 6'd22);
    repeat (3) @(negedge clk);
    chk("t6_valid", opnd_valid, 1);
    chk("t6_data", opnd_data, {64'd42, 64'd41, 64'd40});
    chk("t6_tag", opnd_tag, 22);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
